// File: rtl/tankb_sample_player_if.sv
// Sample ROM read bus between a tankb_sample_player (master) and its sample ROM (slave).
interface tankb_sample_player_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport master (output rom_rd, output rom_addr, input rom_data);
  modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/tankb_sample_player.sv
// One-shot PCM sample player for Tank Battalion effects, streamed from an external ROM.
// Define SAMPLE_LOOP_EN to loop the sample seamlessly while the trigger stays high.
module tankb_sample_player #(
  parameter int unsigned SAMPLE_LEN = 52095,
  parameter int unsigned CLK_DIV    = 1632,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         trigger_i,
  tankb_sample_player_if.master        rom,
  output logic                         busy_o,
  output logic [15:0]                  sound_out_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SAMPLE_LEN - 1);
  localparam logic [DivW-1:0]   DivLoad  = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StPlay} state_e;

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic [7:0]        sample_q, sample_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              trig_q;
  logic              start;
  logic              loop_ok;

  assign start = trigger_i & ~trig_q;

`ifdef SAMPLE_LOOP_EN
  assign loop_ok = trigger_i;
`else
  assign loop_ok = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    div_d    = div_q;
    // A new edge always restarts from address 0, even on the end-of-sample tick.
    if (start) begin
      addr_d  = '0;
      rd_d    = 1'b1;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StIdle: sample_d = '0;
        StFetch: state_d = StWait;
        StWait: begin
          sample_d = rom.rom_data;
          div_d    = DivLoad;
          busy_d   = 1'b1;
          state_d  = StPlay;
        end
        StPlay: begin
          if (div_q != '0) begin
            div_d = div_q - 1'b1;
          end else if (addr_q != LastAddr) begin
            addr_d  = addr_q + 1'b1;
            rd_d    = 1'b1;
            state_d = StFetch;
          end else if (loop_ok) begin
            addr_d  = '0;
            rd_d    = 1'b1;
            state_d = StFetch;
          end else begin
            sample_d = '0;
            busy_d   = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      sample_q <= '0;
      div_q    <= '0;
      trig_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      div_q    <= div_d;
      trig_q   <= trigger_i;
    end
  end

  assign rom.rom_rd   = rd_q;
  assign rom.rom_addr = addr_q;
  assign busy_o       = busy_q;
  assign sound_out_o  = {2'b00, sample_q, 6'b000000};

endmodule

// File: tb/tb_tankb_sample_player.sv
// Self-checking bench for tankb_sample_player against a cycle-offset playback model.
module tb_tankb_sample_player;

  localparam int LEN = 4;
  localparam int DIV = 4;
  localparam int PER = DIV + 2;
`ifdef SAMPLE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        trig;
  logic        busy;
  logic [15:0] sound;

  tankb_sample_player_if #(.ADDR_W(16)) bus ();

  tankb_sample_player #(
    .SAMPLE_LEN(LEN),
    .CLK_DIV   (DIV),
    .ADDR_W    (16)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .trigger_i  (trig),
    .rom        (bus.master),
    .busy_o     (busy),
    .sound_out_o(sound)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous sample ROM: ROM[i] = 0x10*(i+1), data one clock after the read strobe.
  always_ff @(posedge clk) begin
    if (bus.rom_rd) bus.rom_data <= 8'(16 * ((int'(bus.rom_addr) % LEN) + 1));
  end

  int tests = 0;
  int fails = 0;

  // Playback model: position j counts cycles since the start edge.
  bit          m_act = 1'b0;
  int          m_j = 0;
  logic        m_trq = 1'b1;
  logic [15:0] m_prev_s = '0;
  logic        m_prev_b = 1'b0;
  logic        e_rd = 1'b0;
  logic [15:0] e_addr = '0;
  logic        e_busy = 1'b0;
  logic [15:0] e_sound = '0;

  logic [33:0] dut_vec;
  logic [33:0] exp_vec;
  assign dut_vec = {bus.rom_rd, bus.rom_addr, busy, sound};
  assign exp_vec = {e_rd, e_addr, e_busy, e_sound};

  function automatic logic [15:0] scale(input int k);
    logic [7:0] s;
    s = 8'((k + 1) * 16);
    return {2'b00, s, 6'b000000};
  endfunction

  task automatic model_step();
    bit start;
    int k;
    int p;
    if (rst) begin
      m_act = 1'b0; m_trq = 1'b1;
      e_rd = 1'b0; e_addr = '0; e_busy = 1'b0; e_sound = '0;
    end else begin
      start = trig && !m_trq;
      m_trq = trig;
      if (start) begin
        m_prev_s = e_sound; m_prev_b = e_busy; m_act = 1'b1; m_j = 0;
      end else if (m_act) begin
        m_j++;
        if (m_j == LEN * PER) begin
          if (LOOP && trig) begin
            m_prev_s = e_sound; m_prev_b = 1'b1; m_j = 0;
          end else begin
            m_act = 1'b0;
          end
        end
      end
      if (m_act) begin
        k = m_j / PER;
        p = m_j % PER;
        e_rd    = (p == 0);
        e_addr  = 16'(k);
        e_sound = (p >= 2) ? scale(k) : ((k > 0) ? scale(k - 1) : m_prev_s);
        e_busy  = (k == 0 && p < 2) ? m_prev_b : 1'b1;
      end else begin
        e_rd = 1'b0; e_busy = 1'b0; e_sound = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 1'b1;
    repeat (3) tick();
    tests++;
    if (dut_vec !== 34'h0) begin
      fails++; $display("FAIL reset_state got %h exp %h", dut_vec, 34'h0);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec || bus.rom_rd !== 1'b0) begin
        fails++; $display("FAIL reset_hold_trigger c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_start_latency();
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    tests++;
    if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 16'h0) begin
      fails++; $display("FAIL start_rd got rd=%b addr=%h exp rd=1 addr=0", bus.rom_rd, bus.rom_addr);
    end
    trig = 1'b0;
    for (int c = 1; c < 30; c++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL latency_model c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
      if (c == 2) begin
        tests++;
        if (sound !== 16'h0400 || busy !== 1'b1) begin
          fails++; $display("FAIL first_sample got snd=%h busy=%b exp 0400 1", sound, busy);
        end
      end
      if (c == 6) begin
        tests++;
        if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 16'h1) begin
          fails++; $display("FAIL addr1_read got rd=%b addr=%h exp 1 1", bus.rom_rd, bus.rom_addr);
        end
      end
    end
  endtask

  task automatic test_playback();
    int pulses = 0;
    trig = 1'b0; tick();
    trig = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 0) trig = 1'b0;
      if (bus.rom_rd === 1'b1) pulses++;
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL playback c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
    tests++;
    if (pulses != LEN || sound !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL playback_end got pulses=%0d snd=%h busy=%b exp %0d 0000 0", pulses, sound, busy, LEN);
    end
  endtask

  task automatic test_retrigger();
    int pulses = 0;
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    trig = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL retrig_pre c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
    trig = 1'b1; tick();
    trig = 1'b0;
    tests++;
    if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 16'h0 || sound !== 16'h0c00) begin
      fails++;
      $display("FAIL retrig_rd got rd=%b addr=%h snd=%h exp 1 0 0c00", bus.rom_rd, bus.rom_addr, sound);
    end
    pulses = 1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (bus.rom_rd === 1'b1) pulses++;
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL retrig_post c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
    tests++;
    if (pulses != LEN) begin
      fails++; $display("FAIL retrig_pulses got %0d exp %0d", pulses, LEN);
    end
  endtask

  task automatic test_reset_mid();
    trig = 1'b0; tick();
    trig = 1'b1; tick();
    for (int c = 1; c <= 10; c++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    tests++;
    if (dut_vec !== 34'h0) begin
      fails++; $display("FAIL reset_mid got %h exp %h", dut_vec, 34'h0);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec || bus.rom_rd !== 1'b0) begin
        fails++; $display("FAIL reset_mid_after c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
    trig = 1'b0; tick();
  endtask

  task automatic test_hold();
    trig = 1'b0; tick();
    trig = 1'b1;
    for (int c = 0; c < 2 * LEN * PER + 3; c++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL hold c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
`ifdef SAMPLE_LOOP_EN
      if (c == LEN * PER) begin
        tests++;
        if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 16'h0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL loop_seamless got rd=%b addr=%h busy=%b exp 1 0 1", bus.rom_rd, bus.rom_addr, busy);
        end
      end
`endif
    end
    trig = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL hold_release c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
    tests++;
    if (busy !== 1'b0 || sound !== 16'h0) begin
      fails++; $display("FAIL hold_idle got busy=%b snd=%h exp 0 0000", busy, sound);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) trig = ~trig;
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++; $display("FAIL random c=%0d got %h exp %h", c, dut_vec, exp_vec);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b1;
    test_reset();
    test_start_latency();
    test_playback();
    test_retrigger();
    test_reset_mid();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
